// File: rtl/noc_test_node_pkg.sv
// Noc_parameters: mesh geometry, packet format and flit layout shared by
// every NoC test node, its flit interface and its receive checker.
package Noc_parameters;

  localparam int Noc_X_Size   = 2;
  localparam int Noc_Y_Size   = 2;
  localparam int Noc_Node_Num = Noc_X_Size * Noc_Y_Size;
  localparam int Pkt_Len      = 4;

  // Coordinate fields never collapse to zero width on a 1-wide mesh.
  localparam int Coord_X_W = (Noc_X_Size > 1) ? $clog2(Noc_X_Size) : 1;
  localparam int Coord_Y_W = (Noc_Y_Size > 1) ? $clog2(Noc_Y_Size) : 1;
  localparam int Payload_W = 32;
  localparam int Flit_W    = 2 + 2 * Coord_X_W + 2 * Coord_Y_W + Payload_W;

  typedef enum logic [1:0] {
    FLIT_HEAD = 2'd0,
    FLIT_BODY = 2'd1,
    FLIT_TAIL = 2'd2
  } flit_type_e;

  typedef struct packed {
    flit_type_e             ftype;
    logic [Coord_X_W-1:0]   dst_x;
    logic [Coord_Y_W-1:0]   dst_y;
    logic [Coord_X_W-1:0]   src_x;
    logic [Coord_Y_W-1:0]   src_y;
    logic [Payload_W-1:0]   payload;
  } flit_t;

  // Destination of the packet with sequence number seq sent from self_idx;
  // a node never addresses itself, so a self hit is pushed to the next node.
  function automatic int unsigned dest_index(input int unsigned self_idx,
                                             input logic [7:0]  seq);
    int unsigned d;
    d = (self_idx + 32'd1 + 32'(seq)) % Noc_Node_Num;
    if (d == self_idx) begin
      d = (d + 32'd1) % Noc_Node_Num;
    end
    return d;
  endfunction

endpackage

// File: rtl/noc_test_node_if.sv
// Noc_flit_interface: one valid/ready flit channel between a node and the
// mesh fabric. The sender drives valid/flit, the receiver drives ready.
interface Noc_flit_interface;
  import Noc_parameters::*;

  logic  valid;
  logic  ready;
  flit_t flit;

  modport sender   (output valid, output flit, input  ready);
  modport receiver (input  valid, input  flit, output ready);

endinterface

// File: rtl/noc_test_node_rx_checker.sv
// noc_rx_checker: sinks every flit ejected to this node, checks addressing,
// HEAD/BODY/TAIL sequencing, flit index and source tag, and counts packets.
module noc_rx_checker
  import Noc_parameters::*;
#(
  parameter int X_ID = 0,
  parameter int Y_ID = 0
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_valid,
  input  flit_t       i_flit,
  output logic        o_ready,
  output logic [15:0] o_pkt_cnt,
  output logic        o_err
);

  localparam logic [7:0] Last_Idx = 8'(Pkt_Len - 1);

  logic        r_ready;
  logic [7:0]  r_idx;
  logic [15:0] r_pkt_cnt;
  logic        r_err;

  logic        w_accept;
  flit_type_e  w_exp_type;
  logic        w_dst_bad;
  logic        w_type_bad;
  logic        w_idx_bad;
  logic        w_src_bad;
  logic        w_any_bad;
  logic        w_is_tail;
  logic [7:0]  w_src_idx;
  logic        w_unused_bits;

  // The sequence number and zero byte are carried for debug only.
  assign w_unused_bits = ^i_flit.payload[23:8];

  // Combinational checks of the flit currently presented on the port.
  always_comb begin
    w_accept   = i_valid && r_ready;
    w_exp_type = FLIT_BODY;
    if (r_idx == 8'd0) begin
      w_exp_type = FLIT_HEAD;
    end else if (r_idx == Last_Idx) begin
      w_exp_type = FLIT_TAIL;
    end else begin
      w_exp_type = FLIT_BODY;
    end
    w_dst_bad  = (i_flit.dst_x != Coord_X_W'(X_ID)) ||
                 (i_flit.dst_y != Coord_Y_W'(Y_ID));
    w_type_bad = (i_flit.ftype != w_exp_type);
    w_idx_bad  = (i_flit.payload[7:0] != r_idx);
    w_src_idx  = 8'(32'(i_flit.src_y) * Noc_X_Size + 32'(i_flit.src_x));
    w_src_bad  = (i_flit.payload[31:24] != w_src_idx);
    w_is_tail  = (i_flit.ftype == FLIT_TAIL);
    w_any_bad  = w_dst_bad || w_type_bad || w_idx_bad || w_src_bad;
  end

  // Expected-index tracking, sticky error flag and received-packet counter.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ready   <= 1'b0;
      r_idx     <= 8'd0;
      r_pkt_cnt <= 16'd0;
      r_err     <= 1'b0;
    end else begin
      r_ready <= 1'b1;
      if (w_accept) begin
        if (w_any_bad) begin
          r_err <= 1'b1;
        end
        if (w_is_tail) begin
          r_pkt_cnt <= r_pkt_cnt + 16'd1;
          r_idx     <= 8'd0;
        end else if (r_idx == Last_Idx) begin
          // Over-long packet: resynchronise instead of running off the end.
          r_idx <= 8'd0;
        end else begin
          r_idx <= r_idx + 8'd1;
        end
      end
    end
  end

  assign o_ready   = r_ready;
  assign o_pkt_cnt = r_pkt_cnt;
  assign o_err     = r_err;

endmodule

// File: rtl/noc_test_node.sv
// noc_test_node: traffic endpoint on one mesh local port. A start pulse
// injects one Pkt_Len-flit packet to a rotating destination; everything the
// fabric ejects here is checked by noc_rx_checker.
module noc_test_node
  import Noc_parameters::*;
#(
  parameter int X_ID = 0,
  parameter int Y_ID = 0
) (
  input  logic                noc_clk,
  input  logic                noc_rst_n,
  input  logic                send_start,
  Noc_flit_interface.sender   noc_sender_if,
  Noc_flit_interface.receiver noc_receiver_if,
  output logic [15:0]         tx_pkt_cnt,
  output logic [15:0]         rx_pkt_cnt,
  output logic                rx_err
);

  localparam int unsigned Self_Idx   = Y_ID * Noc_X_Size + X_ID;
  localparam logic [7:0]  Self_Idx_B = 8'(Self_Idx);
  localparam logic [7:0]  Last_K     = 8'(Pkt_Len - 1);

  typedef enum logic [0:0] {
    TX_IDLE = 1'b0,
    TX_SEND = 1'b1
  } tx_state_e;

  tx_state_e            r_state;
  logic                 r_valid;
  flit_t                r_flit;
  logic [7:0]           r_seq;
  logic [7:0]           r_k;
  logic                 r_pending;
  logic [15:0]          r_tx_cnt;
  logic [Coord_X_W-1:0] r_dst_x;
  logic [Coord_Y_W-1:0] r_dst_y;

  int unsigned          w_next_d;
  logic [Coord_X_W-1:0] w_next_dst_x;
  logic [Coord_Y_W-1:0] w_next_dst_y;
  logic                 w_rx_ready;

  function automatic flit_type_e type_for(input logic [7:0] k);
    flit_type_e t;
    if (k == 8'd0) begin
      t = FLIT_HEAD;
    end else if (k == Last_K) begin
      t = FLIT_TAIL;
    end else begin
      t = FLIT_BODY;
    end
    return t;
  endfunction

  function automatic flit_t build_flit(input logic [Coord_X_W-1:0] dx,
                                       input logic [Coord_Y_W-1:0] dy,
                                       input logic [7:0]           seq,
                                       input logic [7:0]           k);
    flit_t f;
    f.ftype   = type_for(k);
    f.dst_x   = dx;
    f.dst_y   = dy;
    f.src_x   = Coord_X_W'(X_ID);
    f.src_y   = Coord_Y_W'(Y_ID);
    f.payload = {Self_Idx_B, seq, 8'd0, k};
    return f;
  endfunction

  // Destination coordinates for the packet that would start now.
  always_comb begin
    w_next_d     = dest_index(Self_Idx, r_seq);
    w_next_dst_x = Coord_X_W'(w_next_d % Noc_X_Size);
    w_next_dst_y = Coord_Y_W'(w_next_d / Noc_X_Size);
  end

  // Transmit FSM: start/pending handling, flit sequencing, seq and tx count.
  always_ff @(posedge noc_clk) begin
    if (noc_rst_n) begin
      r_state   <= TX_IDLE;
      r_valid   <= 1'b0;
      r_flit    <= '0;
      r_seq     <= 8'd0;
      r_k       <= 8'd0;
      r_pending <= 1'b0;
      r_tx_cnt  <= 16'd0;
      r_dst_x   <= '0;
      r_dst_y   <= '0;
    end else begin
      case (r_state)
        TX_IDLE: begin
          if (send_start || r_pending) begin
            r_pending <= 1'b0;
            r_dst_x   <= w_next_dst_x;
            r_dst_y   <= w_next_dst_y;
            r_k       <= 8'd0;
            r_valid   <= 1'b1;
            r_flit    <= build_flit(w_next_dst_x, w_next_dst_y, r_seq, 8'd0);
            r_state   <= TX_SEND;
          end else begin
            r_valid <= 1'b0;
          end
        end
        TX_SEND: begin
          // One request is remembered; extra pulses fold into it.
          if (send_start) begin
            r_pending <= 1'b1;
          end
          if (noc_sender_if.ready) begin
            if (r_k == Last_K) begin
              r_valid  <= 1'b0;
              r_flit   <= '0;
              r_seq    <= r_seq + 8'd1;
              r_tx_cnt <= r_tx_cnt + 16'd1;
              r_state  <= TX_IDLE;
            end else begin
              r_k    <= r_k + 8'd1;
              r_flit <= build_flit(r_dst_x, r_dst_y, r_seq, r_k + 8'd1);
            end
          end
        end
        default: begin
          r_state <= TX_IDLE;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  noc_rx_checker #(
    .X_ID (X_ID),
    .Y_ID (Y_ID)
  ) u_rx_checker (
    .i_clk     (noc_clk),
    .i_rst     (noc_rst_n),
    .i_valid   (noc_receiver_if.valid),
    .i_flit    (noc_receiver_if.flit),
    .o_ready   (w_rx_ready),
    .o_pkt_cnt (rx_pkt_cnt),
    .o_err     (rx_err)
  );

  assign noc_receiver_if.ready = w_rx_ready;
  assign noc_sender_if.valid   = r_valid;
  assign noc_sender_if.flit    = r_flit;
  assign tx_pkt_cnt            = r_tx_cnt;

endmodule

// File: tb/tb_noc_test_node.sv
// Bench for noc_test_node at node (0,0) of a 2x2 mesh: random backpressure
// and random receive traffic against a packet-level reference model.
module tb_noc_test_node;
  import Noc_parameters::*;

  localparam int TB_S = 0;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        send_start = 1'b0;
  logic [15:0] tx_cnt;
  logic [15:0] rx_cnt;
  logic        rx_err;

  Noc_flit_interface tx_if ();
  Noc_flit_interface rx_if ();

  noc_test_node #(.X_ID(0), .Y_ID(0)) dut (
    .noc_clk         (clk),
    .noc_rst_n       (rst),
    .send_start      (send_start),
    .noc_sender_if   (tx_if),
    .noc_receiver_if (rx_if),
    .tx_pkt_cnt      (tx_cnt),
    .rx_pkt_cnt      (rx_cnt),
    .rx_err          (rx_err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  int m_seq = 0;
  int m_tx  = 0;
  int m_rx  = 0;

  // ---------------- reference model ----------------
  function automatic flit_type_e pos_type(int k);
    if (k == 0) return FLIT_HEAD;
    if (k == Pkt_Len - 1) return FLIT_TAIL;
    return FLIT_BODY;
  endfunction

  function automatic flit_t mk_flit(flit_type_e t, int dx, int dy, int sx, int sy,
                                    logic [31:0] pl);
    flit_t f;
    f.ftype   = t;
    f.dst_x   = Coord_X_W'(dx);
    f.dst_y   = Coord_Y_W'(dy);
    f.src_x   = Coord_X_W'(sx);
    f.src_y   = Coord_Y_W'(sy);
    f.payload = pl;
    return f;
  endfunction

  function automatic flit_t model_tx_flit(int seq, int k);
    int s8;
    int d;
    s8 = seq % 256;
    d  = (TB_S + 1 + s8) % Noc_Node_Num;
    if (d == TB_S) d = (d + 1) % Noc_Node_Num;
    return mk_flit(pos_type(k), d % Noc_X_Size, d / Noc_X_Size, 0, 0,
                   {8'(TB_S), 8'(s8), 8'h00, 8'(k)});
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs the transmit side until one packet's TAIL is accepted.
  // mode 0: ready high, 1: three-cycle stall on the first BODY, 2: random ready.
  // pulses: bit c asserts send_start during loop cycle c.
  task automatic tx_collect(input int mode, input int budget, input logic [31:0] pulses);
    int    k = 0;
    int    cyc = 0;
    int    stall_left = 0;
    bit    stalled_once = 0;
    bit    prev_stall = 0;
    bit    done = 0;
    flit_t prev_flit = '0;
    flit_t exp_f;
    while (!done && cyc < budget) begin
      if (mode == 1 && k == 1 && tx_if.valid && !stalled_once) begin
        stall_left   = 3;
        stalled_once = 1;
      end
      case (mode)
        1: tx_if.ready = (stall_left > 0) ? 1'b0 : 1'b1;
        2: tx_if.ready = 1'($urandom % 2);
        default: tx_if.ready = 1'b1;
      endcase
      if (stall_left > 0) stall_left--;
      send_start = (cyc < 32) ? pulses[cyc] : 1'b0;
      if (prev_stall) begin
        n_vec++;
        if (tx_if.valid !== 1'b1 || tx_if.flit !== prev_flit) begin
          n_bad++;
          $display("FAIL hold_stable: got valid=%b flit=%h required valid=1 flit=%h",
                   tx_if.valid, tx_if.flit, prev_flit);
        end
      end
      if (tx_if.valid && tx_if.ready) begin
        exp_f = model_tx_flit(m_seq, k);
        n_vec++;
        if (tx_if.flit !== exp_f) begin
          n_bad++;
          $display("FAIL tx_flit seq=%0d k=%0d: got %h required %h",
                   m_seq, k, tx_if.flit, exp_f);
        end
        k++;
        if (k == Pkt_Len) done = 1;
      end
      prev_stall = tx_if.valid && !tx_if.ready;
      prev_flit  = tx_if.flit;
      tick();
      cyc++;
    end
    send_start  = 1'b0;
    tx_if.ready = 1'b1;
    n_vec++;
    if (!done) begin
      n_bad++;
      $display("FAIL tx_timeout: got %0d flits required %0d within %0d cycles",
               k, Pkt_Len, budget);
    end else begin
      m_seq++;
      m_tx++;
      if (tx_cnt !== 16'(m_tx)) begin
        n_bad++;
        $display("FAIL tx_pkt_cnt: got %0d required %0d", tx_cnt, m_tx);
      end
    end
  endtask

  task automatic rx_send(input flit_t f);
    rx_if.valid = 1'b1;
    rx_if.flit  = f;
    tick();
    rx_if.valid = 1'b0;
    rx_if.flit  = '0;
  endtask

  task automatic rx_good_packet(input int sx, input int sy);
    for (int k = 0; k < Pkt_Len; k++) begin
      rx_send(mk_flit(pos_type(k), 0, 0, sx, sy,
                      {8'(sy * Noc_X_Size + sx), 8'($urandom), 8'h00, 8'(k)}));
      if ($urandom % 2 == 1) tick();
    end
    m_rx++;
  endtask

  task automatic check_rx(input string name, input logic exp_err);
    n_vec++;
    if (rx_cnt !== 16'(m_rx) || rx_err !== exp_err) begin
      n_bad++;
      $display("FAIL %s: got rx_cnt=%0d rx_err=%b required rx_cnt=%0d rx_err=%b",
               name, rx_cnt, rx_err, m_rx, exp_err);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    n_vec++;
    if (tx_if.valid !== 1'b0 || tx_if.flit !== '0 || rx_if.ready !== 1'b0 ||
        tx_cnt !== 16'd0 || rx_cnt !== 16'd0 || rx_err !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_state: got v=%b f=%h rdy=%b tx=%0d rx=%0d err=%b required all zero",
               tx_if.valid, tx_if.flit, rx_if.ready, tx_cnt, rx_cnt, rx_err);
    end
    rst = 1'b0;
    tick();
    n_vec++;
    if (rx_if.ready !== 1'b1) begin
      n_bad++;
      $display("FAIL rx_ready_after_reset: got %b required 1", rx_if.ready);
    end
  endtask

  task automatic test_single_packet();
    flit_t exp_f;
    tx_if.ready = 1'b1;
    send_start  = 1'b1;
    tick();
    send_start  = 1'b0;
    for (int k = 0; k < Pkt_Len; k++) begin
      exp_f = model_tx_flit(m_seq, k);
      n_vec++;
      if (tx_if.valid !== 1'b1 || tx_if.flit !== exp_f) begin
        n_bad++;
        $display("FAIL single_flit k=%0d: got v=%b %h required v=1 %h",
                 k, tx_if.valid, tx_if.flit, exp_f);
      end
      tick();
    end
    m_seq++;
    m_tx++;
    n_vec++;
    if (tx_cnt !== 16'(m_tx) || tx_if.valid !== 1'b0) begin
      n_bad++;
      $display("FAIL single_done: got tx=%0d v=%b required tx=%0d v=0",
               tx_cnt, tx_if.valid, m_tx);
    end
  endtask

  task automatic test_backpressure();
    tx_collect(1, 16, 32'h1);
    for (int i = 0; i < 6; i++) tx_collect(2, 80, 32'h1);
  endtask

  task automatic test_pending();
    // Start, then a pulse that becomes pending, then one that must be dropped.
    tx_collect(0, 8, 32'b1101);
    // Second packet must follow within one idle cycle of the TAIL.
    tx_collect(0, Pkt_Len + 2, 32'h0);
    for (int i = 0; i < 8; i++) begin
      tick();
      n_vec++;
      if (tx_if.valid !== 1'b0 || tx_cnt !== 16'(m_tx)) begin
        n_bad++;
        $display("FAIL pulse_dropped: got v=%b tx=%0d required v=0 tx=%0d",
                 tx_if.valid, tx_cnt, m_tx);
      end
    end
  endtask

  task automatic test_rx_good();
    rx_good_packet(1, 1);
    check_rx("rx_from_1_1", 1'b0);
    for (int i = 0; i < 5; i++) begin
      rx_good_packet(int'($urandom_range(1, 0)), int'($urandom_range(1, 0)));
      check_rx("rx_random_good", 1'b0);
    end
  endtask

  task automatic test_rx_errors();
    rx_send(mk_flit(FLIT_BODY, 0, 0, 1, 0, {8'd1, 8'd0, 8'd0, 8'd0}));
    check_rx("rx_body_no_head", 1'b1);
    rx_good_packet(1, 0);
    check_rx("rx_err_sticky", 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    m_rx = 0; m_tx = 0; m_seq = 0;
    check_rx("rx_err_cleared", 1'b0);
    rx_send(mk_flit(FLIT_HEAD, 1, 0, 1, 1, {8'd3, 8'd0, 8'd0, 8'd0}));
    check_rx("rx_wrong_dst", 1'b1);
    for (int i = 0; i < 4; i++) begin
      rx_send(mk_flit(FLIT_TAIL, 0, 0, 0, 1, {8'd2, 8'd0, 8'd0, 8'd0}));
      m_rx++;
    end
    check_rx("rx_err_stays", 1'b1);
  endtask

  task automatic test_reset_mid_send();
    tx_if.ready = 1'b1;
    send_start  = 1'b1;
    tick();
    send_start  = 1'b0;
    tick();
    send_start  = 1'b1;  // leaves a pending request that reset must drop
    tick();
    send_start  = 1'b0;
    rx_send(mk_flit(FLIT_HEAD, 0, 0, 1, 0, {8'd1, 8'd0, 8'd0, 8'd0}));
    rst = 1'b1;
    tick();
    n_vec++;
    if (tx_if.valid !== 1'b0 || tx_cnt !== 16'd0 || rx_cnt !== 16'd0 ||
        rx_err !== 1'b0 || rx_if.ready !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_mid_send: got v=%b tx=%0d rx=%0d err=%b rdy=%b required 0",
               tx_if.valid, tx_cnt, rx_cnt, rx_err, rx_if.ready);
    end
    rst = 1'b0;
    m_seq = 0; m_tx = 0; m_rx = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      n_vec++;
      if (tx_if.valid !== 1'b0) begin
        n_bad++;
        $display("FAIL pending_cleared: got v=%b required 0", tx_if.valid);
      end
    end
    tx_collect(2, 60, 32'h1);
    rx_good_packet(1, 0);
    check_rx("rx_after_reset", 1'b0);
  endtask

  initial begin
    tx_if.ready = 1'b1;
    rx_if.valid = 1'b0;
    rx_if.flit  = '0;
    test_reset();
    test_single_packet();
    test_backpressure();
    test_pending();
    test_rx_good();
    test_rx_errors();
    test_reset_mid_send();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
